// File: rtl/spi_peripheral_oversampled_if.sv
// Pin-side and selector-side signals of the oversampled SPI target.
// The slave modport is the target's view; master is the host/selector side.
interface spi_peripheral_oversampled_if;
  logic       spi_select_in;
  logic       spi_clock_in;
  logic       spi_data_in;
  logic       spi_data_out;
  logic [7:0] address_out;
  logic       address_out_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [7:0] peripheral_data_in;
  logic       peripheral_data_in_valid;

  modport slave (
    input  spi_select_in, spi_clock_in, spi_data_in,
    input  peripheral_data_in, peripheral_data_in_valid,
    output spi_data_out, address_out, address_out_valid,
    output data_out, data_out_valid
  );

  modport master (
    output spi_select_in, spi_clock_in, spi_data_in,
    output peripheral_data_in, peripheral_data_in_valid,
    input  spi_data_out, address_out, address_out_valid,
    input  data_out, data_out_valid
  );
endinterface

// File: rtl/spi_peripheral_oversampled.sv
// SPI mode-0 target oversampled by clock_in: first byte of a frame is the
// address, later bytes are writes from MOSI while the selector's byte goes out on MISO.
module spi_peripheral_oversampled #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input logic                           clock_in,
  input logic                           reset_n_in,
  spi_peripheral_oversampled_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ADDRESS, DATA} state_e;

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, cs_fill_q;
  logic                   cs_prev_q, sck_prev_q, armed_q;

  logic cs_s, sck_s, mosi_s;
  logic cs_rise, cs_fall, sck_rise, sck_fall;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chains.
  // NOTE: the CS_n chain resets to 1 (deselected) so reset never looks like a
  // frame already in progress; cs_fill_q marks stages that hold real pin data.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_fill_q   <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[LAST-1:0],   bus.spi_select_in};
      sck_sync_q  <= {sck_sync_q[LAST-1:0],  bus.spi_clock_in};
      mosi_sync_q <= {mosi_sync_q[LAST-1:0], bus.spi_data_in};
      cs_fill_q   <= {cs_fill_q[LAST-1:0],   1'b1};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
      // A frame may only start after CS_n has genuinely been seen high.
      if (cs_fill_q[LAST] && cs_s) armed_q <= 1'b1;
    end
  end

  assign cs_s     = cs_sync_q[LAST];
  assign sck_s    = sck_sync_q[LAST];
  assign mosi_s   = mosi_sync_q[LAST];
  assign cs_rise  =  cs_s  & ~cs_prev_q;
  assign cs_fall  = ~cs_s  &  cs_prev_q;
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q;
  logic [6:0] tx_q;
  logic [7:0] address_q, data_q;
  logic       address_valid_q, data_valid_q, miso_q;
  logic [7:0] rx_d;

  assign rx_d = {rx_q[6:0], mosi_s};

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      rx_q            <= '0;
      tx_q            <= '0;
      address_q       <= '0;
      address_valid_q <= 1'b0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      miso_q          <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (cs_rise) begin
        // Deselect beats any SCK edge seen in the same cycle; partial bytes drop.
        state_q         <= IDLE;
        bit_cnt_q       <= '0;
        address_valid_q <= 1'b0;
        miso_q          <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall && armed_q) begin
              state_q   <= ADDRESS;
              bit_cnt_q <= '0;
            end
          end
          ADDRESS: begin
            if (sck_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                address_q       <= rx_d;
                address_valid_q <= 1'b1;
                state_q         <= DATA;
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                data_q       <= rx_d;
                data_valid_q <= 1'b1;
              end
            end
            if (sck_fall) begin
              if (bit_cnt_q == 3'd0) begin
                // Byte boundary: load the selector's byte, or zeros if not valid.
                if (bus.peripheral_data_in_valid) begin
                  miso_q <= bus.peripheral_data_in[7];
                  tx_q   <= bus.peripheral_data_in[6:0];
                end else begin
                  miso_q <= 1'b0;
                  tx_q   <= '0;
                end
              end else begin
                miso_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.spi_data_out      = miso_q;
  assign bus.address_out       = address_q;
  assign bus.address_out_valid = address_valid_q;
  assign bus.data_out          = data_q;
  assign bus.data_out_valid    = data_valid_q;

endmodule

// File: tb/tb_spi_peripheral_oversampled.sv
// Directed bench for spi_peripheral_oversampled: bit-banged SPI host on the
// pins, hand-computed expected bytes, pulse monitor on data_out_valid.
module tb_spi_peripheral_oversampled;

  localparam int HALF = 8;  // SCK half period in clock_in cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_peripheral_oversampled_if bus();

  spi_peripheral_oversampled #(.SYNC_STAGES(2)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Capture every data_out_valid pulse and flag any lasting more than one cycle.
  logic [7:0] pulse_q[$];
  int         wide_cnt = 0;
  logic       dv_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.data_out_valid === 1'b1) begin
      pulse_q.push_back(bus.data_out);
      if (dv_prev) wide_cnt <= wide_cnt + 1;
    end
    dv_prev <= (bus.data_out_valid === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_data_in = tx[i];
      idle(HALF);
      rx[i] = bus.spi_data_out;
      bus.spi_clock_in = 1'b1;
      idle(HALF);
      bus.spi_clock_in = 1'b0;
    end
  endtask

  task automatic frame_begin();
    bus.spi_select_in = 1'b0;
    idle(6);
  endtask

  task automatic frame_end();
    idle(HALF);
    bus.spi_select_in = 1'b1;
    idle(10);
  endtask

  logic [7:0] rx;

  initial begin
    bus.spi_select_in            = 1'b1;
    bus.spi_clock_in             = 1'b0;
    bus.spi_data_in              = 1'b0;
    bus.peripheral_data_in       = 8'h00;
    bus.peripheral_data_in_valid = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(6);

    // Reset state
    check("rst_addr",   bus.address_out,       8'h00);
    check("rst_avalid", bus.address_out_valid, 1'b0);
    check("rst_data",   bus.data_out,          8'h00);
    check("rst_dvalid", bus.data_out_valid,    1'b0);
    check("rst_miso",   bus.spi_data_out,      1'b0);

    // Address-only frame
    pulse_q.delete();
    frame_begin();
    xfer(8'hBB, 8, rx);
    idle(2);
    check("ao_addr",   bus.address_out,       8'hBB);
    check("ao_avalid", bus.address_out_valid, 1'b1);
    frame_end();
    check("ao_avalid_end", bus.address_out_valid, 1'b0);
    check("ao_addr_hold",  bus.address_out,       8'hBB);
    check("ao_pulses",     pulse_q.size(),        0);

    // Read frame with valid selector data
    pulse_q.delete();
    bus.peripheral_data_in       = 8'hA5;
    bus.peripheral_data_in_valid = 1'b1;
    frame_begin();
    xfer(8'hBB, 8, rx);
    check("rd_miso_addr_phase", rx, 8'h00);
    xfer(8'h00, 8, rx);
    check("rd_miso",    rx,             8'hA5);
    frame_end();
    check("rd_pulses",  pulse_q.size(), 1);
    check("rd_pulse0",  pulse_q[0],     8'h00);
    check("rd_miso_idle", bus.spi_data_out, 1'b0);

    // Invalid read data returns zeros
    bus.peripheral_data_in       = 8'hFF;
    bus.peripheral_data_in_valid = 1'b0;
    frame_begin();
    xfer(8'h01, 8, rx);
    xfer(8'h00, 8, rx);
    check("inv_miso", rx, 8'h00);
    frame_end();

    // Multi-byte write
    pulse_q.delete();
    frame_begin();
    xfer(8'h00, 8, rx);
    xfer(8'h12, 8, rx);
    xfer(8'h34, 8, rx);
    xfer(8'h56, 8, rx);
    check("mb_addr", bus.address_out, 8'h00);
    frame_end();
    check("mb_pulses", pulse_q.size(), 3);
    check("mb_p0",     pulse_q[0],     8'h12);
    check("mb_p1",     pulse_q[1],     8'h34);
    check("mb_p2",     pulse_q[2],     8'h56);
    check("mb_width",  wide_cnt,       0);

    // Aborted second data byte
    pulse_q.delete();
    frame_begin();
    xfer(8'h3C, 8, rx);
    xfer(8'h77, 8, rx);
    xfer(8'hE0, 5, rx);
    frame_end();
    check("ab_pulses",  pulse_q.size(),        1);
    check("ab_p0",      pulse_q[0],            8'h77);
    check("ab_avalid",  bus.address_out_valid, 1'b0);
    check("ab_data_hold", bus.data_out,        8'h77);
    pulse_q.delete();
    frame_begin();
    xfer(8'h5A, 8, rx);
    xfer(8'h99, 8, rx);
    check("ab_next_addr", bus.address_out, 8'h5A);
    frame_end();
    check("ab_next_pulses", pulse_q.size(), 1);
    check("ab_next_p0",     pulse_q[0],     8'h99);

    // Reset mid-frame, released with CS_n still low
    bus.peripheral_data_in       = 8'hFF;
    bus.peripheral_data_in_valid = 1'b1;
    frame_begin();
    xfer(8'hE7, 8, rx);
    xfer(8'hF0, 4, rx);
    check("mr_pre_avalid", bus.address_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_addr",   bus.address_out,       8'h00);
    check("mr_avalid", bus.address_out_valid, 1'b0);
    check("mr_data",   bus.data_out,          8'h00);
    check("mr_miso",   bus.spi_data_out,      1'b0);
    idle(3);
    rst_n = 1'b1;
    pulse_q.delete();
    idle(6);
    xfer(8'hC3, 8, rx);
    check("mr_ign_miso0", rx, 8'h00);
    xfer(8'h81, 8, rx);
    check("mr_ign_miso1", rx, 8'h00);
    idle(4);
    check("mr_ign_avalid", bus.address_out_valid, 1'b0);
    check("mr_ign_addr",   bus.address_out,       8'h00);
    check("mr_ign_pulses", pulse_q.size(),        0);
    frame_end();
    frame_begin();
    xfer(8'h42, 8, rx);
    xfer(8'h24, 8, rx);
    check("mr_new_miso", rx, 8'hFF);
    check("mr_new_addr", bus.address_out, 8'h42);
    frame_end();
    check("mr_new_pulses", pulse_q.size(), 1);
    check("mr_new_p0",     pulse_q[0],     8'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
